// File: rtl/ahbl_arb2.sv
// ahbl_arb2: two-master to one-slave AHB-Lite arbiter.
//
// Each master gets one pending slot. A request that loses arbitration, or that
// arrives while the slave is stalling, is captured there, and the master sees
// HREADY low until the held request is forwarded. Arbitration is combinational.
// The winner drives the shared address phase in the same cycle in which the
// slave is ready.
//
// Ports:
//   HCLK, HRESETN            clock, asynchronous active-low reset
//   Mn_HADDR..Mn_HWDATA      address/control/write data from master n
//   Mn_HRDATA/HREADY/HRESP   read data and handshake back to master n
//   S_HADDR..S_HMASTLOCK     arbitrated address phase to the slave
//   S_HWDATA                 write data of the current data-phase owner
//   S_HRDATA/HREADY/HRESP    slave read data and handshake
//   S_HMASTER                master owning the current slave address phase
//   PRIORITY_MODE            0 = round-robin, 1 = fixed priority (M0 wins)
module ahbl_arb2 #(
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HMASTLOCK,
    input  logic [31:0] M0_HWDATA,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,
    output logic        M0_HRESP,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HMASTLOCK,
    input  logic [31:0] M1_HWDATA,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,
    output logic        M1_HRESP,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic        S_HWRITE,
    output logic [2:0]  S_HSIZE,
    output logic        S_HMASTLOCK,
    output logic [31:0] S_HWDATA,
    input  logic [31:0] S_HRDATA,
    input  logic        S_HREADY,
    input  logic        S_HRESP,
    output logic        S_HMASTER
);

    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic        lock;
    } phase_t;

    phase_t     live [2];
    phase_t     cand [2];
    phase_t     pend_q [2];
    phase_t     pend_d [2];
    logic [1:0] pend_flag_q, pend_flag_d;
    logic [1:0] hready_m;
    logic [1:0] present;
    logic [1:0] cand_vld;

    logic       rr_last_q, rr_last_d;   // winner of the last two-way contest
    logic       hmaster_q, hmaster_d;
    logic       down_q, down_d;
    logic       dvalid_q, dvalid_d;
    logic       locked_q, locked_d;
    phase_t     held_q, held_d;

    logic       win_vld;
    logic       win_idx;
    logic       fwd;
    phase_t     s_phase;
    logic       s_hmaster;

    assign live[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HMASTLOCK};
    assign live[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HMASTLOCK};

    // The data-phase owner follows the slave. A master with a held request is
    // stalled so that it cannot present a second one.
    always_comb begin
        hready_m = '1;
        for (int n = 0; n < 2; n++) begin
            if (dvalid_q && (down_q == 1'(n))) begin
                hready_m[n] = S_HREADY;
            end else if (pend_flag_q[n]) begin
                hready_m[n] = 1'b0;
            end
        end
    end

    // BUSY (01) counts as no request, so HTRANS[1] alone marks NONSEQ/SEQ.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            present[n]  = live[n].trans[1] & hready_m[n];
            cand[n]     = pend_flag_q[n] ? pend_q[n] : live[n];
            cand_vld[n] = pend_flag_q[n] | present[n];
        end
    end

    // While a lock is held, only the lock owner (the last address-phase
    // master) may be granted.
    always_comb begin
        win_vld = 1'b0;
        win_idx = hmaster_q;
        if (locked_q) begin
            win_vld = cand_vld[hmaster_q];
        end else if (&cand_vld) begin
            win_vld = 1'b1;
            win_idx = (PRIORITY_MODE == 1) ? 1'b0 : ~rr_last_q;
        end else if (cand_vld[0]) begin
            win_vld = 1'b1;
            win_idx = 1'b0;
        end else if (cand_vld[1]) begin
            win_vld = 1'b1;
            win_idx = 1'b1;
        end
    end

    // Address phase seen by the slave. It is held while the slave stalls.
    always_comb begin
        s_phase   = held_q;
        s_hmaster = hmaster_q;
        if (!HRESETN) begin
            s_phase   = '0;
            s_hmaster = 1'b0;
        end else if (S_HREADY) begin
            if (win_vld) begin
                s_phase   = cand[win_idx];
                s_hmaster = win_idx;
                // A burst that was interleaved has to restart as NONSEQ.
                if (s_phase.trans == HtransSeq && win_idx != hmaster_q) begin
                    s_phase.trans = HtransNonseq;
                end
            end else begin
                s_phase = '0;
                // An idle lock owner keeps the bus, and its own lock bit decides
                // whether the lock stays asserted.
                if (locked_q) begin
                    s_phase.lock = live[hmaster_q].lock;
                end
            end
        end
    end

    assign fwd = HRESETN & S_HREADY & win_vld;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            pend_flag_d[n] = pend_flag_q[n];
            pend_d[n]      = pend_q[n];
            if (fwd && (win_idx == 1'(n))) begin
                pend_flag_d[n] = 1'b0;
            end else if (present[n] && !pend_flag_q[n]) begin
                pend_flag_d[n] = 1'b1;
                pend_d[n]      = live[n];
            end
        end

        rr_last_d = rr_last_q;
        if (fwd && (&cand_vld) && !locked_q) begin
            rr_last_d = win_idx;
        end

        hmaster_d = s_hmaster;
        held_d    = s_phase;

        down_d   = down_q;
        dvalid_d = dvalid_q;
        locked_d = locked_q;
        if (S_HREADY) begin
            down_d   = s_hmaster;
            dvalid_d = s_phase.trans[1];
            locked_d = s_phase.trans[1] ? s_phase.lock : (locked_q & s_phase.lock);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            pend_flag_q <= '0;
            pend_q[0]   <= '0;
            pend_q[1]   <= '0;
            rr_last_q   <= 1'b1;
            hmaster_q   <= 1'b0;
            down_q      <= 1'b0;
            dvalid_q    <= 1'b0;
            locked_q    <= 1'b0;
            held_q      <= '0;
        end else begin
            pend_flag_q <= pend_flag_d;
            pend_q[0]   <= pend_d[0];
            pend_q[1]   <= pend_d[1];
            rr_last_q   <= rr_last_d;
            hmaster_q   <= hmaster_d;
            down_q      <= down_d;
            dvalid_q    <= dvalid_d;
            locked_q    <= locked_d;
            held_q      <= held_d;
        end
    end

    assign S_HADDR     = s_phase.addr;
    assign S_HTRANS    = s_phase.trans;
    assign S_HWRITE    = s_phase.write;
    assign S_HSIZE     = s_phase.size;
    assign S_HMASTLOCK = s_phase.lock;
    assign S_HMASTER   = s_hmaster;
    assign S_HWDATA    = down_q ? M1_HWDATA : M0_HWDATA;

    assign M0_HREADY = hready_m[0];
    assign M1_HREADY = hready_m[1];
    assign M0_HRESP  = dvalid_q & ~down_q & S_HRESP;
    assign M1_HRESP  = dvalid_q & down_q & S_HRESP;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

endmodule

// File: doc/ahbl_arb2.md
AHBL_ARB2 -- requirements
Module: ahbl_arb2

Interface
REQ-001 SHALL have parameter PRIORITY_MODE, default 0: 0 = round-robin between masters, 1 = fixed priority, M0 always wins.
REQ-002 SHALL have HCLK  in  1  single clock for all logic.
REQ-003 SHALL have HRESETN  in  1  asynchronous, active-low reset.
REQ-004 SHALL have Mn_HADDR  in  32  address of master n (n = 0, 1; same for REQ-005..012).
REQ-005 SHALL have Mn_HTRANS  in  2  transfer type of master n.
REQ-006 SHALL have Mn_HWRITE  in  1  write flag of master n.
REQ-007 SHALL have Mn_HSIZE  in  3  transfer size of master n.
REQ-008 SHALL have Mn_HMASTLOCK  in  1  lock request of master n.
REQ-009 SHALL have Mn_HWDATA  in  32  write data of master n.
REQ-010 SHALL have Mn_HRDATA  out  32  read data returned to master n.
REQ-011 SHALL have Mn_HREADY  out  1  ready returned to master n.
REQ-012 SHALL have Mn_HRESP  out  1  response returned to master n.
REQ-013 SHALL have S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HMASTLOCK  out  32/2/1/3/1  arbitrated address phase to the shared slave bus.
REQ-014 SHALL have S_HWDATA  out  32  write data of the data-phase owner.
REQ-015 SHALL have S_HRDATA  in  32  slave read data.
REQ-016 SHALL have S_HREADY  in  1  slave HREADYOUT.
REQ-017 SHALL have S_HRESP  in  1  slave response.
REQ-018 SHALL have S_HMASTER  out  1  index of the master owning the current slave address phase.

Function
REQ-019 SHALL treat master n as presenting a request when Mn_HTRANS is NONSEQ or SEQ and Mn_HREADY=1 at the rising edge; BUSY is treated as IDLE.
REQ-020 SHALL hold, per master, a pending register (HADDR, HTRANS, HWRITE, HSIZE, HMASTLOCK) plus a pending flag.
REQ-021 SHALL set the pending flag when a presented request is not forwarded on that edge, and clear it on the edge the held request is forwarded.
REQ-022 SHALL take master n's candidate request from its pending register when the flag is set, else from its live inputs.
REQ-023 SHALL arbitrate combinationally each cycle and forward the winner onto S_* only when S_HREADY=1; otherwise S_* hold the previous forwarded address phase.
REQ-024 SHALL apply round-robin when PRIORITY_MODE=0 and both masters request: the master not granted last wins. A sole requester always wins.
REQ-025 SHALL set LOCKED when a forwarded transfer has HMASTLOCK=1, and clear it when the lock owner's forwarded phase (IDLE included) has HMASTLOCK=0.
REQ-026 While LOCKED is set, SHALL not grant the other master; if the lock owner is idle, S_HTRANS SHALL be IDLE with S_HMASTLOCK=1.
REQ-027 SHALL convert a forwarded SEQ to NONSEQ when the previous forwarded non-IDLE transfer came from the other master.
REQ-028 With no winner, SHALL drive S_HTRANS=IDLE and S_HADDR=0, and leave S_HMASTER unchanged.
REQ-029 On each edge with S_HREADY=1, SHALL register data-phase owner DOWN = S_HMASTER and DVALID = (forwarded HTRANS non-IDLE).
REQ-030 SHALL drive Mn_HREADY = S_HREADY when DVALID=1 and DOWN=n; else 0 when pending flag n is set; else 1.
REQ-031 SHALL drive Mn_HRESP = S_HRESP when DVALID=1 and DOWN=n, else 0.
REQ-032 SHALL drive Mn_HRDATA = S_HRDATA for both masters.
REQ-033 SHALL drive S_HWDATA = HWDATA of master DOWN.
REQ-034 SHALL never hold more than one pending request per master; a master stalled by Mn_HREADY=0 cannot present another.
REQ-035 SHALL pass two-cycle ERROR responses through unchanged, and SHALL not cancel a pending request on ERROR.

Reset
REQ-036 While HRESETN=0, SHALL immediately (asynchronously) clear pending flags, LOCKED, DVALID, DOWN and S_HMASTER, and set the last-grant register to M1; outputs SHALL be S_HTRANS=IDLE, S_HADDR=0, S_HMASTLOCK=0, Mn_HREADY=1, Mn_HRESP=0.
REQ-037 SHALL discard any in-flight or pending transfer when reset is asserted mid-operation, with no replay after release.

Verification
REQ-038 Only M0 writes 0xA5A5_0001 to 0x100 -> forwarded the same cycle, S_HMASTER=0, S_HWDATA=0xA5A5_0001 next cycle, M1_HREADY stays 1.
REQ-039 M0 reads 0x10 and M1 reads 0x20 on the same edge, PRIORITY_MODE=0, after reset -> M0 forwarded first, M1 pending (M1_HREADY=0 for one data phase), then 0x20 forwarded with S_HMASTER=1.
REQ-040 Repeat REQ-039 three times -> grants alternate 0,1,1,0,0,1; with PRIORITY_MODE=1, M0 always wins.
REQ-041 M1 performs a locked read-modify-write on 0x40 while M0 requests continuously -> no M0 transfer appears between the two M1 transfers; M0 is forwarded after M1 issues HMASTLOCK=0.
REQ-042 M1 is mid INCR burst (SEQ to 0x204) when M0 is interleaved -> 0x204 appears on S_HTRANS as NONSEQ; slave waits of 3 cycles stall only the data-phase owner.
REQ-043 Assert HRESETN low while M1 is pending -> all Mn_HREADY=1 and S_HTRANS=IDLE immediately; after release the pending transfer is never forwarded.
